count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 150 +++++++++++++++
 tb/tb_count_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: watches a free-running 32-bit counter stream, acquires lock
// after LOCK_COUNT consecutive in-sequence samples, and keeps statistics on
// sequence errors and legal wraps.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_UNLOCKED | no reference sample yet; next valid sample seeds prev
// ST_ACQUIRE  | counting consecutive in-sequence samples toward lock
// ST_LOCKED   | stream trusted; mismatches raise err, zero raises restart
module count_monitor #(
  parameter int LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_vld,
  input  logic [31:0] cnt,
  input  logic        clr_err,
  output logic        locked,
  output logic        err,
  output logic        err_sticky,
  output logic [15:0] err_cnt,
  output logic [15:0] wrap_cnt,
  output logic        restart,
  output logic [31:0] last_cnt
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [31:0] prev_q, prev_d;
  logic [31:0] last_cnt_q, last_cnt_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic        restart_q, restart_d;
  logic        err_sticky_q, err_sticky_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] wrap_cnt_q, wrap_cnt_d;

  logic [31:0] expected;
  logic [7:0]  good_inc;
  logic        in_seq;

  assign expected = prev_q + 32'd1;
  assign good_inc = good_q + 8'd1;
  assign in_seq   = (cnt == expected);

  // Sequence tracking: state, good count, sample history, pulses and wraps.
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    prev_d     = prev_q;
    last_cnt_d = last_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = 1'b0;
    restart_d  = 1'b0;
    if (cnt_vld) begin
      prev_d     = cnt;
      last_cnt_d = cnt;
      unique case (state_q)
        ST_UNLOCKED: begin
          good_d  = 8'd0;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (in_seq) begin
            good_d = good_inc;
            if (good_inc >= LOCK_TARGET) state_d = ST_LOCKED;
          end else begin
            good_d    = 8'd0;
            restart_d = (cnt == 32'd0);
          end
        end
        ST_LOCKED: begin
          if (in_seq) begin
            if (prev_q == 32'hFFFF_FFFF && wrap_cnt_q != 16'hFFFF)
              wrap_cnt_d = wrap_cnt_q + 16'd1;
          end else begin
            good_d  = 8'd0;
            state_d = ST_ACQUIRE;
            // A zero that breaks sequence is a counter restart, not an error.
            if (cnt == 32'd0) restart_d = 1'b1;
            else              err_d     = 1'b1;
          end
        end
        default: begin
          good_d  = 8'd0;
          state_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  // Error statistics: a new error takes priority over a coincident clear.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (err_d) begin
      err_sticky_d = 1'b1;
      if (clr_err)                    err_cnt_d = 16'd1;
      else if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = 16'd0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Register all state and outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      good_q       <= 8'd0;
      prev_q       <= 32'd0;
      last_cnt_q   <= 32'd0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      restart_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 16'd0;
      wrap_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      prev_q       <= prev_d;
      last_cnt_q   <= last_cnt_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      restart_q    <= restart_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign restart    = restart_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign last_cnt   = last_cnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with LOCK_COUNT = 4.
module tb_count_monitor;

  logic        clk;
  logic        rst;
  logic        cnt_vld;
  logic [31:0] cnt;
  logic        clr_err;
  logic        locked;
  logic        err;
  logic        err_sticky;
  logic [15:0] err_cnt;
  logic [15:0] wrap_cnt;
  logic        restart;
  logic [31:0] last_cnt;

  int n_checks;
  int n_errors;

  count_monitor #(.LOCK_COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_vld   (cnt_vld),
    .cnt       (cnt),
    .clr_err   (clr_err),
    .locked    (locked),
    .err       (err),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt),
    .restart   (restart),
    .last_cnt  (last_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One valid sample; returns 1 time unit after the capturing edge.
  task automatic send(input logic [31:0] v, input logic clr = 1'b0);
    @(negedge clk);
    cnt_vld = 1'b1;
    cnt     = v;
    clr_err = clr;
    @(posedge clk);
    #1;
    cnt_vld = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic idle(input logic clr = 1'b0);
    @(negedge clk);
    cnt_vld = 1'b0;
    cnt     = 32'hDEAD_BEEF;
    clr_err = clr;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_locked",   32'(locked), 32'd0);
    chk("rst_err",      32'(err), 32'd0);
    chk("rst_restart",  32'(restart), 32'd0);
    chk("rst_sticky",   32'(err_sticky), 32'd0);
    chk("rst_err_cnt",  32'(err_cnt), 32'd0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    chk("rst_last_cnt", last_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    cnt_vld  = 1'b0;
    cnt      = 32'd0;
    clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    pulse_rst();

    // Lock-up: 10..14
    send(32'd10);
    chk("acq_first_locked", 32'(locked), 32'd0);
    chk("acq_first_last", last_cnt, 32'd10);
    send(32'd11); send(32'd12); send(32'd13);
    chk("lock_13_locked", 32'(locked), 32'd0);
    send(32'd14);
    chk("lock_14_locked", 32'(locked), 32'd1);
    chk("lock_14_err", 32'(err), 32'd0);
    chk("lock_14_last", last_cnt, 32'd14);

    // Counter restart while locked at 25
    for (int v = 15; v <= 25; v++) send(32'(v));
    chk("at25_locked", 32'(locked), 32'd1);
    send(32'd0);
    chk("restart_pulse", 32'(restart), 32'd1);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_locked", 32'(locked), 32'd0);
    send(32'd1);
    chk("restart_once", 32'(restart), 32'd0);
    send(32'd2); send(32'd3);
    chk("restart_3_locked", 32'(locked), 32'd0);
    send(32'd4);
    chk("restart_relock", 32'(locked), 32'd1);
    chk("restart_err_cnt", 32'(err_cnt), 32'd0);

    // Glitch while locked at 50
    for (int v = 5; v <= 50; v++) send(32'(v));
    send(32'd52);
    chk("glitch_err", 32'(err), 32'd1);
    chk("glitch_err_cnt", 32'(err_cnt), 32'd1);
    chk("glitch_sticky", 32'(err_sticky), 32'd1);
    chk("glitch_locked", 32'(locked), 32'd0);
    send(32'd53);
    chk("glitch_err_one_cycle", 32'(err), 32'd0);
    send(32'd54); send(32'd55); send(32'd56);
    chk("glitch_relock", 32'(locked), 32'd1);
    chk("glitch_sticky_held", 32'(err_sticky), 32'd1);

    // Drive err_cnt to 3, then clear coinciding with an error
    send(32'd100);
    for (int v = 101; v <= 104; v++) send(32'(v));
    send(32'd200);
    for (int v = 201; v <= 204; v++) send(32'(v));
    chk("three_errs", 32'(err_cnt), 32'd3);
    chk("three_relock", 32'(locked), 32'd1);
    send(32'd300, 1'b1);
    chk("clr_vs_err_cnt", 32'(err_cnt), 32'd1);
    chk("clr_vs_err_sticky", 32'(err_sticky), 32'd1);
    idle(1'b1);
    chk("clr_alone_cnt", 32'(err_cnt), 32'd0);
    chk("clr_alone_sticky", 32'(err_sticky), 32'd0);

    // Wrap while locked
    pulse_rst();
    for (int v = 9; v >= 5; v--) send(32'hFFFF_FFFF - 32'(v) + 32'd3);
    chk("wrap_prelock", 32'(locked), 32'd1);
    chk("wrap_prelock_last", last_cnt, 32'hFFFF_FFFD);
    send(32'hFFFF_FFFE);
    chk("wrap_fe_err", 32'(err) | 32'(restart), 32'd0);
    send(32'hFFFF_FFFF);
    chk("wrap_ff_err", 32'(err) | 32'(restart), 32'd0);
    chk("wrap_ff_cnt", 32'(wrap_cnt), 32'd0);
    send(32'd0);
    chk("wrap_0_err", 32'(err) | 32'(restart), 32'd0);
    chk("wrap_0_cnt", 32'(wrap_cnt), 32'd1);
    chk("wrap_0_locked", 32'(locked), 32'd1);
    send(32'd1);
    chk("wrap_1_err", 32'(err) | 32'(restart), 32'd0);
    chk("wrap_1_locked", 32'(locked), 32'd1);
    idle(1'b1);
    chk("clr_keeps_wrap", 32'(wrap_cnt), 32'd1);

    // Gaps keep lock
    for (int v = 2; v <= 7; v++) send(32'(v));
    repeat (5) begin
      idle();
      chk("gap_locked", 32'(locked), 32'd1);
      chk("gap_last", last_cnt, 32'd7);
    end
    send(32'd8);
    chk("gap_8_locked", 32'(locked), 32'd1);
    chk("gap_8_err", 32'(err), 32'd0);

    // Reset mid-stream, then restart acquisition at 100
    pulse_rst();
    send(32'd100);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_err", 32'(err) | 32'(restart), 32'd0);
    chk("post_rst_last", last_cnt, 32'd100);
    send(32'd101); send(32'd102); send(32'd103);
    chk("post_rst_103", 32'(locked), 32'd0);
    send(32'd104);
    chk("post_rst_relock", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
